// File: rtl/tile_spawner_pkg.sv
// tile_pkg: shared constants and helpers for the tile spawner.
//   - Board geometry: 16 cells of 4-bit log2 exponents packed into 64 bits.
//   - Exponent codes for empty / tile 2 / tile 4.
//   - FSM state encoding (IDLE, SCAN, DONE).
//   - Galois LFSR tap mask and step function.
//   - Cell read/write helpers for the packed board.
package tile_pkg;

    localparam int N_CELLS = 16;
    localparam int CELL_W  = 4;
    localparam int IDX_W   = 4;
    localparam int BOARD_W = 64;

    localparam logic [CELL_W-1:0] EXP_EMPTY = 4'd0;
    localparam logic [CELL_W-1:0] EXP_TWO   = 4'd1;
    localparam logic [CELL_W-1:0] EXP_FOUR  = 4'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // One Galois step: shift right, fold the taps in when a 1 falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        lfsr_next = q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
    endfunction

    function automatic logic [CELL_W-1:0] get_cell(input logic [BOARD_W-1:0] b,
                                                   input logic [IDX_W-1:0]   i);
        get_cell = b[{i, 2'b00} +: CELL_W];
    endfunction

    function automatic logic [BOARD_W-1:0] set_cell(input logic [BOARD_W-1:0] b,
                                                    input logic [IDX_W-1:0]   i,
                                                    input logic [CELL_W-1:0]  v);
        logic [BOARD_W-1:0] r;
        r = b;
        r[{i, 2'b00} +: CELL_W] = v;
        set_cell = r;
    endfunction

endpackage

// File: rtl/tile_spawner_if.sv
// tile_spawner_if: request/result bundle between the move engine and the
// tile spawner.
//   master (engine side): drives spawn_req, board_in; observes results.
//   slave  (spawner)    : receives request, drives busy/done/full,
//                         cell_idx/cell_val, board_out and rnd_o.
interface tile_spawner_if;
    import tile_pkg::*;

    logic                spawn_req;
    logic [BOARD_W-1:0]  board_in;
    logic                busy;
    logic                done;
    logic                full;
    logic [IDX_W-1:0]    cell_idx;
    logic [CELL_W-1:0]   cell_val;
    logic [BOARD_W-1:0]  board_out;
    logic [15:0]         rnd_o;

    modport master (
        output spawn_req, board_in,
        input  busy, done, full, cell_idx, cell_val, board_out, rnd_o
    );

    modport slave (
        input  spawn_req, board_in,
        output busy, done, full, cell_idx, cell_val, board_out, rnd_o
    );

endinterface

// File: rtl/tile_spawner_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (mask 16'hB400).
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   seed : reset value; an all-zero seed is replaced by 16'h0001 because
//          the zero state would lock the register up forever
//   q    : current state (registered)
module lfsr16
    import tile_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] seed_s;

    // Zero-seed guard.
    always_comb begin
        if (seed == 16'h0000) begin
            seed_s = 16'h0001;
        end else begin
            seed_s = seed;
        end
    end

    // Advance every cycle while out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= seed_s;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/tile_spawner.sv
// tile_spawner: places one new tile (2 or 4) into a random empty cell of the
// 4x4 board. A request snapshots the board and picks a start cell and tile
// value from the LFSR; cells are then probed one per cycle, wrapping 15->0,
// until an empty one is found or all 16 have been tried.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : tile_spawner_if.slave (request, board in, results, LFSR state)
//   SEED        : LFSR reset value (0 is promoted to 1)
//   FOUR_THRESH : value nibble below this spawns a 4, otherwise a 2
module tile_spawner
    import tile_pkg::*;
#(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic [3:0]  FOUR_THRESH = 4'd2
)
(
    input  logic           clk,
    input  logic           rst,
    tile_spawner_if.slave  bus
);

    logic [1:0]          state_r;
    logic [1:0]          state_s;
    logic [BOARD_W-1:0]  brd_r;
    logic [IDX_W-1:0]    ptr_r;
    logic [3:0]          probes_r;
    logic [CELL_W-1:0]   val_r;
    logic [CELL_W-1:0]   cell_s;
    logic                busy_r;
    logic                done_r;
    logic                full_r;
    logic [IDX_W-1:0]    cell_idx_r;
    logic [CELL_W-1:0]   cell_val_r;
    logic [BOARD_W-1:0]  board_out_r;
    logic [15:0]         rnd_s;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .q    (rnd_s)
    );

    // Cell currently under the probe pointer.
    always_comb begin
        cell_s = get_cell(brd_r, ptr_r);
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.spawn_req) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if ((cell_s == EXP_EMPTY) || (probes_r == 4'd15)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state, scan datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            brd_r       <= 64'h0;
            ptr_r       <= 4'd0;
            probes_r    <= 4'd0;
            val_r       <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            full_r      <= 1'b0;
            cell_idx_r  <= 4'd0;
            cell_val_r  <= 4'd0;
            board_out_r <= 64'h0;
        end else begin
            state_r <= state_s;
            // busy/done are registered copies of the next state so they line
            // up exactly with the state they describe.
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (bus.spawn_req) begin
                        brd_r    <= bus.board_in;
                        ptr_r    <= rnd_s[3:0];
                        probes_r <= 4'd0;
                        val_r    <= (rnd_s[7:4] < FOUR_THRESH) ? EXP_FOUR : EXP_TWO;
                    end
                end
                ST_SCAN: begin
                    if (cell_s == EXP_EMPTY) begin
                        brd_r       <= set_cell(brd_r, ptr_r, val_r);
                        board_out_r <= set_cell(brd_r, ptr_r, val_r);
                        cell_idx_r  <= ptr_r;
                        cell_val_r  <= val_r;
                        full_r      <= 1'b0;
                    end else if (probes_r == 4'd15) begin
                        board_out_r <= brd_r;
                        cell_idx_r  <= 4'd0;
                        cell_val_r  <= 4'd0;
                        full_r      <= 1'b1;
                    end else begin
                        ptr_r    <= ptr_r + 4'd1;
                        probes_r <= probes_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    brd_r <= brd_r;
                end
                default: begin
                    brd_r <= brd_r;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.full      = full_r;
    assign bus.cell_idx  = cell_idx_r;
    assign bus.cell_val  = cell_val_r;
    assign bus.board_out = board_out_r;
    assign bus.rnd_o     = rnd_s;

endmodule

// File: tb/tb_tile_spawner.sv
// tb_tile_spawner: scoreboard bench for tile_spawner. Expected results come
// from an independent LFSR model and a reference placement function; they
// are queued when a request is issued and compared when done pulses.
module tb_tile_spawner;
    import tile_pkg::*;

    typedef struct packed {
        logic        full;
        logic [3:0]  idx;
        logic [3:0]  val;
        logic [63:0] board;
        logic [5:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_spawner_if bus ();
    tile_spawner_if bus0 ();

    tile_spawner #(.SEED(16'hACE1), .FOUR_THRESH(4'd2)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
    tile_spawner #(.SEED(16'h0000), .FOUR_THRESH(4'd2)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    exp_t        sb[$];
    logic [15:0] mdl;
    int unsigned cyc;
    int unsigned first_ret = 0;
    bit          zero_seen = 1'b0;
    bit          mon_en = 1'b0;
    int          done_cnt = 0;

    localparam logic [63:0] WRAP_BOARD = 64'h1234_5678_9ABC_D0EF;

    // Reference LFSR, written from the polynomial independently of the RTL.
    always @(posedge clk or negedge rst) begin
        if (!rst) mdl <= 16'hACE1;
        else      mdl <= mdl[0] ? ((mdl >> 1) ^ 16'hB400) : (mdl >> 1);
    end

    // Cycles since reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Period monitor for rnd_o.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (bus.rnd_o == 16'h0000) zero_seen <= 1'b1;
            if (bus.rnd_o == 16'hACE1 && cyc != 0 && first_ret == 0) first_ret <= cyc;
        end
    end

    // Count done pulses.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    function automatic exp_t ref_spawn(input logic [63:0] b, input logic [15:0] r);
        exp_t e;
        logic [3:0] p;
        logic [3:0] v;
        logic [3:0] kk;
        v = (r[7:4] < 4'd2) ? 4'd2 : 4'd1;
        e.full = 1'b1; e.idx = 4'd0; e.val = 4'd0; e.board = b; e.lat = 6'd17;
        for (int k = 0; k < 16; k++) begin
            kk = k[3:0];
            p = r[3:0] + kk;
            if (b[{p, 2'b00} +: 4] == 4'd0) begin
                e.full = 1'b0; e.idx = p; e.val = v;
                e.board[{p, 2'b00} +: 4] = v;
                e.lat = 6'(k + 2);
                break;
            end
        end
        return e;
    endfunction

    task automatic wait_rnd(input logic [15:0] mask, input logic [15:0] want, output bit ok);
        int n;
        n = 0;
        while (((mdl & mask) != want) && n < 70000) begin
            @(posedge clk); #1; n++;
        end
        ok = ((mdl & mask) == want);
    endtask

    // Drive a one-cycle request; returns #1 after the accepting edge.
    task automatic issue(input logic [63:0] b);
        sb.push_back(ref_spawn(b, mdl));
        bus.board_in  = b;
        bus.spawn_req = 1'b1;
        @(posedge clk); #1;
        bus.spawn_req = 1'b0;
    endtask

    // Scoreboard consumer: waits for done, pops and compares. poke_at pulses
    // spawn_req so it is sampled at accept-edge + poke_at; poke_done pulses it
    // in the done cycle; board_in is scrambled after acceptance.
    task automatic sb_collect(input string nm, input int poke_at, input bit poke_done);
        exp_t e;
        int   n;
        bit   got;
        bit   busy_bad;
        n = 0; got = 1'b0; busy_bad = 1'b0;
        while (!got && n < 40) begin
            bus.spawn_req = (poke_at == n + 1) ? 1'b1 : 1'b0;
            @(posedge clk); #1; n++;
            bus.board_in = {$urandom, $urandom};
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            if (bus.done === 1'b1) got = 1'b1;
        end
        chk_cnt++;
        if (!got) $display("FAIL %s_done_timeout: no done within %0d cycles", nm, n);
        else pass_cnt++;
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            chk_cnt++;
            if (bus.full !== e.full) $display("FAIL %s_full: got %b want %b", nm, bus.full, e.full);
            else pass_cnt++;
            chk_cnt++;
            if (bus.cell_idx !== e.idx) $display("FAIL %s_idx: got %0d want %0d", nm, bus.cell_idx, e.idx);
            else pass_cnt++;
            chk_cnt++;
            if (bus.cell_val !== e.val) $display("FAIL %s_val: got %0d want %0d", nm, bus.cell_val, e.val);
            else pass_cnt++;
            chk_cnt++;
            if (bus.board_out !== e.board) $display("FAIL %s_board: got %h want %h", nm, bus.board_out, e.board);
            else pass_cnt++;
            chk_cnt++;
            if (n + 1 != int'(e.lat)) $display("FAIL %s_latency: got T+%0d want T+%0d", nm, n + 1, e.lat);
            else pass_cnt++;
            chk_cnt++;
            if (busy_bad) $display("FAIL %s_busy_during: got busy low want high", nm);
            else pass_cnt++;
        end else begin
            sb.delete();
        end
        bus.spawn_req = poke_done;
        @(posedge clk); #1;
        bus.spawn_req = 1'b0;
        chk_cnt++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL %s_after_done: got busy=%b done=%b want 0 0", nm, bus.busy, bus.done);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if ({bus.busy, bus.done, bus.full} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.full});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.cell_idx, bus.cell_val} !== 8'h00)
            $display("FAIL reset_cell: got %h want 00", {bus.cell_idx, bus.cell_val});
        else pass_cnt++;
        chk_cnt++;
        if (bus.board_out !== 64'h0) $display("FAIL reset_board: got %h want 0", bus.board_out);
        else pass_cnt++;
        chk_cnt++;
        if (bus.rnd_o !== 16'hACE1) $display("FAIL reset_rnd: got %h want ace1", bus.rnd_o);
        else pass_cnt++;
        chk_cnt++;
        if (bus0.rnd_o !== 16'h0001) $display("FAIL zero_seed_rnd: got %h want 0001", bus0.rnd_o);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (bus.rnd_o !== mdl) $display("FAIL lfsr_step: got %h want %h", bus.rnd_o, mdl);
        else pass_cnt++;
    endtask

    task automatic test_empty();
        bit ok;
        wait_rnd(16'hFFFF, 16'h5231, ok);
        chk_cnt++;
        if (!ok) $display("FAIL empty_wait: rnd %h never reached 5231", mdl);
        else pass_cnt++;
        issue(64'h0);
        sb_collect("empty", 0, 1'b0);
    endtask

    task automatic test_wrap();
        bit ok;
        wait_rnd(16'h00FF, 16'h000E, ok);
        chk_cnt++;
        if (!ok) $display("FAIL wrap_wait: rnd low byte never 0e");
        else pass_cnt++;
        issue(WRAP_BOARD);
        sb_collect("wrap", 0, 1'b0);
    endtask

    task automatic test_full();
        issue(64'h1111_1111_1111_1111);
        sb_collect("full", 0, 1'b0);
    endtask

    task automatic test_busy_reject();
        bit ok;
        int d0;
        wait_rnd(16'h00FF, 16'h000E, ok);
        chk_cnt++;
        if (!ok) $display("FAIL busy_wait: rnd low byte never 0e");
        else pass_cnt++;
        d0 = done_cnt;
        issue(WRAP_BOARD);
        sb_collect("busy", 2, 1'b1);
        repeat (25) @(posedge clk);
        #1;
        chk_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL busy_done_count: got %0d want 1", done_cnt - d0);
        else pass_cnt++;
        chk_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL busy_idle: got %b want 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_lfsr_period();
        while (cyc < 32'd65536) begin
            @(posedge clk); #1;
        end
        mon_en = 1'b0;
        chk_cnt++;
        if (zero_seen) $display("FAIL lfsr_zero: got zero state want never");
        else pass_cnt++;
        chk_cnt++;
        if (first_ret != 32'd65535) $display("FAIL lfsr_period: got %0d want 65535", first_ret);
        else pass_cnt++;
    endtask

    task automatic test_reset_midscan();
        int d0;
        issue(64'h1111_1111_1111_1111);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        sb.delete();
        chk_cnt++;
        if ({bus.busy, bus.done, bus.full, bus.cell_idx, bus.cell_val} !== 11'h000)
            $display("FAIL midrst_outputs: got %h want 000",
                     {bus.busy, bus.done, bus.full, bus.cell_idx, bus.cell_val});
        else pass_cnt++;
        chk_cnt++;
        if (bus.board_out !== 64'h0) $display("FAIL midrst_board: got %h want 0", bus.board_out);
        else pass_cnt++;
        chk_cnt++;
        if (bus.rnd_o !== 16'hACE1) $display("FAIL midrst_rnd: got %h want ace1", bus.rnd_o);
        else pass_cnt++;
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk_cnt++;
        if (done_cnt != d0 || bus.busy !== 1'b0)
            $display("FAIL midrst_no_done: got %0d dones busy=%b want 0 0", done_cnt - d0, bus.busy);
        else pass_cnt++;
        issue(64'h2101_1121_0111_1211);
        sb_collect("after_rst", 0, 1'b0);
    endtask

    initial begin
        bus.spawn_req  = 1'b0;
        bus.board_in   = 64'h0;
        bus0.spawn_req = 1'b0;
        bus0.board_in  = 64'h0;
        test_reset();
        test_empty();
        test_wrap();
        test_full();
        test_busy_reject();
        test_lfsr_period();
        test_reset_midscan();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/tile_spawner.md
Name: tile_spawner

Overview:
- Consumes pseudo-random bits and places one new tile (value 2 or 4) into a random empty cell of the 4x4 game board.
- Sits between the move/merge engine and the board register. The engine pulses spawn_req after each valid move; the spawner returns the updated board, or flags the board as full (game-over input).
- Contains its own free-running LFSR random source, so no external random generator is required.

Parameters:
- N_CELLS, 16, number of board cells; fixed at 16, index width 4.
- CELL_W, 4, bits per cell: log2 exponent, 0 = empty, 1 = tile 2, 2 = tile 4.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.
- FOUR_THRESH, 4'd2, spawn a 4 when the value nibble is < FOUR_THRESH, else spawn a 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low: asserted when 0.
- spawn_req  in  1  one-cycle request. Ignored unless busy=0.
- board_in  in  64  current board; cell i = board_in[4i+3:4i].
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; result outputs valid in that cycle.
- full  out  1  valid with done: 1 = no empty cell found, nothing placed.
- cell_idx  out  4  index of the cell written; 0 when full.
- cell_val  out  4  exponent written (1 or 2); 0 when full.
- board_out  out  64  board after insertion; held until the next done.
- rnd_o  out  16  current LFSR state, for observation.

Behaviour:
- Reset (rst=0, asynchronous):
  - LFSR = SEED (or 1 if SEED=0).
  - State IDLE.
  - busy, done, full, cell_idx, cell_val = 0; board_out = 0.
  - Reset mid-scan aborts the operation; no done is issued.
- LFSR:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Advances every cycle while out of reset, regardless of state.
  - Never reaches 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On spawn_req=1 at edge T, register the following and go to SCAN:
    - brd = board_in
    - ptr = start = rnd_o[3:0]
    - val = (rnd_o[7:4] < FOUR_THRESH) ? 2 : 1
    - probes = 0
  - All three use rnd_o as sampled at T, before the LFSR advance.
- SCAN (one cell probed per cycle):
  - Cell brd[ptr] == 0:
    - brd[ptr] <= val; cell_idx <= ptr; cell_val <= val; full <= 0.
    - Go to DONE.
  - Else, probes == 15 (16th probe):
    - full <= 1; cell_idx <= 0; cell_val <= 0.
    - Go to DONE.
  - Else: ptr <= ptr+1 (4-bit wrap, 15 -> 0); probes <= probes+1.
- DONE:
  - done=1 for exactly one cycle.
  - board_out = brd (modified, or unchanged when full).
  - Then return to IDLE.
- Latency: if the empty cell is found on probe k (k=0..15), done is high in cycle T+2+k. A full board gives done at T+17.
- busy = (state != IDLE). Therefore busy=1 in the done cycle and 0 the cycle after.
- spawn_req while busy: dropped, not queued.
- spawn_req in the same cycle as done: dropped (state is not IDLE).
- board_in is sampled only at acceptance; later changes are ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package tile_pkg:
  - constants N_CELLS, CELL_W, IDX_W=4, BOARD_W=64
  - EXP_EMPTY=0, EXP_TWO=1, EXP_FOUR=2
  - state encoding IDLE/SCAN/DONE
  - LFSR mask 16'hB400
- Sub-module lfsr16 (clk, rst, seed, q): free-running Galois LFSR with zero-seed guard. Shared with any future random consumer.
- The FSM and cell mux stay in tile_spawner.

Test Plan:
- Empty board: rst=0 for 2 cycles, then release with SEED=16'hACE1. Pulse spawn_req when the bench's LFSR model gives rnd_o=16'h5231.
  - Expect: start=1, val=1 (nibble 3 >= 2); done at T+2.
  - cell_idx=1, cell_val=1, board_out=64'h0000_0000_0000_0010, full=0.
- Wrap search: board_in has all cells nonzero except cell 2; request when rnd_o[3:0]=14, rnd_o[7:4]=0.
  - Expect: probes visit 14, 15, 0, 1, 2; done at T+6.
  - cell_idx=2, cell_val=2 (tile 4); only nibble 2 of board_out changes.
- Full board: board_in=64'h1111_1111_1111_1111.
  - Expect: done at T+17, full=1, cell_idx=0, cell_val=0, board_out=board_in.
  - busy high from T+1 through T+17.
- Busy rejection: with the wrap-search board, request, then pulse spawn_req again at T+2 and in the done cycle.
  - Expect: exactly one done pulse; second operation never starts; busy=0 at T+7.
- Reset mid-scan: full-board request, drive rst=0 at T+5 asynchronously (between edges).
  - Expect: busy, done, full, cell_idx, cell_val, board_out all 0 immediately.
  - rnd_o=16'hACE1; no done after release; a new request afterwards behaves normally.
- LFSR sanity: run 65535 cycles from reset.
  - Expect: rnd_o never 0; returns to 16'hACE1 exactly at cycle 65535.
  - Instantiate with SEED=0 and expect rnd_o=16'h0001 after reset.
